bsa_sum_collector: RTL and testbench
====================================

# bsa_sum_collector

Sequencer and deserializer that sits directly downstream of the bit-serial adder (BSA). It issues the adder's load pulse and counts out the serial sum. It reassembles the LSB-first `sbit` stream into a parallel WL+1-bit word and presents that word on a valid/ready handshake. It guarantees WL+1 shift cycles per operation, so the adder's carry flip-flop returns to 0 before the next load.

## Interface
- `WL`, default 4: operand width of the attached adder; the result is WL+1 bits.
- `LAT`, default 1: clock edges between the adder load edge and the edge after which sum bit 0 is driven on `sbit`; legal range 0..7.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `start` input 1: request a new addition; the operands are already on the adder's a/b inputs.
- `load` output 1: drives the adder `Load`; one-cycle pulse.
- `sbit` input 1: serial sum bit from the adder, LSB first.
- `busy` output 1: high in LOAD, WAIT and SHIFT.
- `sum` output WL+1: assembled result, valid only while `valid` is high.
- `valid` output 1: result available.
- `ready` input 1: consumer accepts the result.

## Operation
- **FSM states:** IDLE, LOAD, WAIT, SHIFT, DONE. All outputs are Moore outputs (registered state only).
- **IDLE:**
  - `start`=1 goes to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:**
  - `load`=1 for exactly one cycle.
  - Go to WAIT with the counter set to LAT.
  - If LAT=0, go directly to SHIFT.
- **WAIT:**
  - `sbit` is ignored.
  - The counter decrements each cycle.
  - Go to SHIFT when the counter would reach 0.
- **SHIFT:**
  - Each edge shifts the capture register right and inserts `sbit` at the MSB.
  - After WL+1 captures, bit k of the sum sits at `sum[k]`.
  - The counter counts 0..WL; on the WL-th capture go to DONE.
- **DONE:**
  - `valid`=1 and `sum` is held stable.
  - `valid`&&`ready` with `start`=0 goes to IDLE.
  - `valid`&&`ready` with `start`=1 goes straight to LOAD (back-to-back).
  - `ready`=0 holds the state indefinitely.
- **Ignored `start`:** `start` is ignored in LOAD, WAIT and SHIFT, and in DONE while `ready`=0. It is not queued.
- **Capture register:** `sum` is the capture register itself. Its contents are not defined outside DONE; benches check `sum` only when `valid`=1.
- **Counter width:** $clog2(max(WL+1, LAT)+1). The counter never wraps; terminal values are compared exactly.

## Timing
- **Reset values:** while `RST`=0, regardless of the clock:
  - state=IDLE
  - `load`=0, `busy`=0, `valid`=0
  - `sum`=0, counter=0
- **Reset mid-operation:** deassertion returns to IDLE with no partial result emitted. The adder is reset by the same net, so no stale carry survives.
- **Full sequence:** let edge E0 be the edge that samples `start`=1 in IDLE.
  - `load` is high in the cycle after E0; the adder loads at E1.
  - Sum bit k is sampled at edge E(2+LAT+k), for k=0..WL.
  - `valid` rises in the cycle after E(2+LAT+WL).
  - Start-to-valid latency is WL+LAT+2 edges (7 at the defaults).
- **Handshake:** the result transfers on the edge where `valid` and `ready` are both 1; `valid` drops in the next cycle unless back-to-back.
- **Back-to-back throughput:** one result per WL+LAT+3 cycles.

## Structure
- **Shared package `bsa_pkg`:**
  - FSM state encoding localparams (S_IDLE=0 … S_DONE=4, 3 bits).
  - A `BSA_RES_W(WL)` width macro/function for WL+1.
- **Sub-module `sipo_shift #(BITS)`:**
  - Serial-in/parallel-out right-shift register with an enable.
  - Instantiated once with BITS=WL+1.
  - Also reusable by other serial datapaths.
- **Top level:** FSM and counter stay in this block; no other hierarchy.

## Test plan
- WL=4, LAT=1: drive the collector from a BSA-equivalent model, a=5, b=3, `ready`=1.
  - `load` pulses once, `valid` asserts 7 edges after `start`, and `sum`=5'b01000.
- a=15, b=15 → `sum`=5'b11110. Then a=0, b=0 → `sum`=0, which proves no carry leaks between operations.
- `ready` held 0 for 10 cycles after `valid`, with `start` pulsed during the wait.
  - `sum` stays stable and `valid` stays high.
  - No `load` is issued until `ready` rises.
- `ready`=1 and `start`=1 held constantly: a=1,b=2 then a=7,b=9.
  - Results are 3 and 16.
  - `load` pulses are spaced exactly 8 cycles apart.
- `RST` pulsed low during SHIFT.
  - All outputs are 0 immediately (asynchronously).
  - The next operation, a=9, b=6, gives 15 with normal latency.
- LAT=0 and LAT=3 builds, a=10, b=11 → 21 in both, with `valid` at 6 and 9 edges respectively.

Source files
------------

// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared state encoding and width helper for the bit-serial adder datapath
package bsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } bsa_state_t;

    // Result of a WL-bit add carries one extra bit.
    function automatic int BSA_RES_W(input int wl);
        return wl + 1;
    endfunction

endpackage

// File: rtl/bsa_sum_collector_if.sv
// rtl/bsa_sum_collector_if.sv - control, serial input and result handshake of the sum collector
interface bsa_sum_collector_if
    import bsa_pkg::*;
#(
    parameter int WL = 4
);
    localparam int RW = BSA_RES_W(WL);

    logic          start;
    logic          load;
    logic          sbit;
    logic          busy;
    logic [RW-1:0] sum;
    logic          valid;
    logic          ready;

    modport master (
        input  start, sbit, ready,
        output load, busy, sum, valid
    );

    modport slave (
        output start, sbit, ready,
        input  load, busy, sum, valid
    );

endinterface

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - serial-in parallel-out right shift register, new bit enters at the MSB
module sipo_shift #(
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            din,
    output logic [BITS-1:0] q
);

    // LSB-first stream: after BITS shifts the first bit lands in q[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[BITS-1:1]};
        end
    end

endmodule

// File: rtl/bsa_sum_collector.sv
// rtl/bsa_sum_collector.sv - sequences the bit-serial adder and deserializes its sum onto valid/ready
module bsa_sum_collector
    import bsa_pkg::*;
#(
    parameter int WL  = 4,
    parameter int LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    bsa_sum_collector_if.master  bus
);

    localparam int RW   = BSA_RES_W(WL);
    localparam int CMAX = (RW > LAT) ? RW : LAT;
    localparam int CW   = $clog2(CMAX + 1);

    bsa_state_t    state;
    logic [CW-1:0] cnt;
    logic          load_q;
    logic          busy_q;
    logic          valid_q;
    logic          shift_en;

    assign shift_en  = (state == S_SHIFT);
    assign bus.load  = load_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

    sipo_shift #(
        .BITS (RW)
    ) u_sipo (
        .clk   (CLK),
        .rst_n (RST),
        .en    (shift_en),
        .din   (bus.sbit),
        .q     (bus.sum)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_LOAD;
                        load_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    load_q <= 1'b0;
                    if (LAT == 0) begin
                        state <= S_SHIFT;
                        cnt   <= '0;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= CW'(LAT);
                    end
                end
                S_WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= S_SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SHIFT: begin
                    // Always WL+1 shifts so the adder carry drains to 0 before the next load.
                    if (cnt == CW'(WL)) begin
                        state   <= S_DONE;
                        cnt     <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        if (bus.start) begin
                            state  <= S_LOAD;
                            load_q <= 1'b1;
                            busy_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsa_sum_collector.sv
// tb/tb_bsa_sum_collector.sv - three collectors (LAT 1, 0, 3) each fed by a bit-serial adder model
module tb_bsa_sum_collector;

    localparam int WL = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] a_v = '0;
    logic [3:0] b_v = '0;
    logic [2:0] start_v = '0;
    logic [2:0] ready_v = 3'b111;
    logic [2:0] load_v;
    logic [2:0] busy_v;
    logic [2:0] valid_v;
    logic [4:0] sum_v [3];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        bsa_sum_collector_if #(.WL(WL)) bus ();

        bsa_sum_collector #(.WL(WL), .LAT(L)) u_dut (
            .CLK (CLK),
            .RST (RST),
            .bus (bus)
        );

        // Bit-serial adder: operand shifters, carry flop, LAT-deep output delay.
        logic [3:0] sa, sb;
        logic       c;
        logic [7:0] dl;
        logic       raw;
        logic [8:0] tap;

        assign raw       = sa[0] ^ sb[0] ^ c;
        assign tap       = {dl, raw};
        assign bus.sbit  = tap[L];
        assign bus.start = start_v[g];
        assign bus.ready = ready_v[g];
        assign load_v[g]  = bus.load;
        assign busy_v[g]  = bus.busy;
        assign valid_v[g] = bus.valid;
        assign sum_v[g]   = bus.sum;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                sa <= '0;
                sb <= '0;
                c  <= 1'b0;
                dl <= '0;
            end else begin
                dl <= {dl[6:0], raw};
                if (bus.load) begin
                    sa <= a_v;
                    sb <= b_v;
                    c  <= 1'b0;
                end else begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    c  <= (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
                end
            end
        end
    end

    typedef struct {
        int         inst;
        logic [3:0] a;
        logic [3:0] b;
        int         exp_sum;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b,
                          input int exp_sum, input int exp_lat, input string tag);
        int   n;
        int   lat;
        int   nload;
        logic busy_seen;
        @(negedge CLK);
        a_v = a;
        b_v = b;
        start_v[i] = 1'b1;
        @(posedge CLK);
        n = 0;
        lat = -1;
        nload = 0;
        @(negedge CLK);
        start_v[i] = 1'b0;
        busy_seen = busy_v[i];
        while (n < 30 && lat < 0) begin
            if (load_v[i]) nload++;
            if (valid_v[i]) begin
                lat = n;
            end else begin
                @(posedge CLK);
                n++;
                @(negedge CLK);
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_sum"}, int'(sum_v[i]), exp_sum);
        check({tag, "_loads"}, nload, 1);
        check({tag, "_busy"}, int'(busy_seen), 1);
        if (ready_v[i]) begin
            @(posedge CLK);
            @(negedge CLK);
            check({tag, "_valid_drop"}, int'(valid_v[i]), 0);
        end
    endtask

    initial begin
        int   n, nl, nv, hold_loads;
        int   lpos [2];
        int   vpos [2];
        int   vsum [2];
        logic stable_ok;

        vecs[0] = '{0, 4'd5,  4'd3,  8,  7};
        vecs[1] = '{0, 4'd15, 4'd15, 30, 7};
        vecs[2] = '{0, 4'd0,  4'd0,  0,  7};
        vecs[3] = '{1, 4'd10, 4'd11, 21, 6};
        vecs[4] = '{2, 4'd10, 4'd11, 21, 9};
        vecs[5] = '{1, 4'd15, 4'd15, 30, 6};
        vecs[6] = '{2, 4'd3,  4'd4,  7,  9};

        // Reset held across clock edges.
        repeat (3) @(negedge CLK);
        check("rst_load",  int'(load_v),  0);
        check("rst_busy",  int'(busy_v),  0);
        check("rst_valid", int'(valid_v), 0);
        check("rst_sum0",  int'(sum_v[0]), 0);
        RST = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k].inst, vecs[k].a, vecs[k].b, vecs[k].exp_sum, vecs[k].exp_lat,
                   $sformatf("vec%0d", k));
        end

        // Consumer stalls; start pulses in DONE must be ignored.
        ready_v[0] = 1'b0;
        run_op(0, 4'd5, 4'd3, 8, 7, "hold");
        stable_ok = 1'b1;
        hold_loads = 0;
        for (int k = 0; k < 10; k++) begin
            start_v[0] = (k == 3);
            @(posedge CLK);
            @(negedge CLK);
            if (!valid_v[0] || sum_v[0] != 5'd8) stable_ok = 1'b0;
            if (load_v[0]) hold_loads++;
        end
        start_v[0] = 1'b0;
        check("hold_stable", int'(stable_ok), 1);
        check("hold_loads", hold_loads, 0);
        ready_v[0] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("hold_release_valid", int'(valid_v[0]), 0);
        check("hold_release_busy",  int'(busy_v[0]),  0);

        // Back-to-back with start and ready held high.
        @(negedge CLK);
        a_v = 4'd1;
        b_v = 4'd2;
        start_v[0] = 1'b1;
        @(posedge CLK);
        n = 0; nl = 0; nv = 0;
        lpos = '{-1, -1};
        vpos = '{-1, -1};
        vsum = '{-1, -1};
        @(negedge CLK);
        while (n < 40 && nv < 2) begin
            if (load_v[0]) begin
                if (nl < 2) lpos[nl] = n;
                nl++;
            end
            if (valid_v[0]) begin
                vpos[nv] = n;
                vsum[nv] = int'(sum_v[0]);
                nv++;
            end
            if (n == 3) begin
                a_v = 4'd7;
                b_v = 4'd9;
            end
            if (nv < 2) begin
                @(posedge CLK);
                n++;
                @(negedge CLK);
            end
        end
        start_v[0] = 1'b0;
        check("b2b_first_valid", vpos[0], 7);
        check("b2b_sum0", vsum[0], 3);
        check("b2b_sum1", vsum[1], 16);
        check("b2b_loads", nl, 2);
        check("b2b_load_spacing", lpos[1] - lpos[0], 8);
        @(posedge CLK);
        @(negedge CLK);
        check("b2b_end_valid", int'(valid_v[0]), 0);

        // Reset asserted in the middle of SHIFT.
        @(negedge CLK);
        a_v = 4'd5;
        b_v = 4'd3;
        start_v[0] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_v[0] = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("mid_busy_before", int'(busy_v[0]), 1);
        RST = 1'b0;
        #1;
        check("mid_rst_load",  int'(load_v[0]),  0);
        check("mid_rst_busy",  int'(busy_v[0]),  0);
        check("mid_rst_valid", int'(valid_v[0]), 0);
        check("mid_rst_sum",   int'(sum_v[0]),   0);
        @(negedge CLK);
        RST = 1'b1;
        run_op(0, 4'd9, 4'd6, 15, 7, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
